// File: rtl/zombie_pkg.sv
// Shared types and constants for the zombie controller and its stepper.
// Facing encoding, sequencer states, spawn coordinates and the off-screen
// park position used for dead zombies live here.
package zombie_pkg;

  typedef enum logic [1:0] {
    FACE_UP    = 2'b00,
    FACE_RIGHT = 2'b01,
    FACE_DOWN  = 2'b10,
    FACE_LEFT  = 2'b11
  } face_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UPD0 = 3'd1,
    UPD1 = 3'd2,
    UPD2 = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int         NUM_ZOMBIES = 3;
  localparam logic [9:0] SPAWN_Y     = 10'd32;
  localparam logic [9:0] PARK_X      = 10'd640;
  localparam logic [9:0] PARK_Y      = 10'd480;

  // Spawn column for each zombie; all share the same spawn row.
  function automatic logic [9:0] spawnX(input int idx);
    case (idx)
      0:       return 10'd32;
      1:       return 10'd304;
      default: return 10'd576;
    endcase
  endfunction

endpackage

// File: rtl/zombie_step.sv
// Combinational chase step for one zombie: moves up to STEP pixels toward
// the player along the axis with the larger distance (ties go to X), never
// past the player, and clamps the result to the playfield.
module zombie_step
  import zombie_pkg::*;
#(
  parameter int STEP  = 1,
  parameter int MAX_X = 608,
  parameter int MAX_Y = 448
) (
  input  logic [9:0] curX_i,
  input  logic [9:0] curY_i,
  input  logic [9:0] playerX_i,
  input  logic [9:0] playerY_i,
  input  face_e      curFace_i,
  output logic [9:0] nextX_o,
  output logic [9:0] nextY_o,
  output face_e      nextFace_o
);

  localparam logic        [10:0] STEP_W = 11'(STEP);
  localparam logic signed [12:0] X_HI   = 13'(MAX_X - 1);
  localparam logic signed [12:0] Y_HI   = 13'(MAX_Y - 1);

  logic signed [10:0] dx, dy;
  logic        [10:0] adx, ady, mag;
  logic signed [12:0] sum;
  logic               moveX;

  // Pick the axis, limit the step to the remaining distance, then clamp.
  always_comb begin
    dx    = $signed({1'b0, playerX_i}) - $signed({1'b0, curX_i});
    dy    = $signed({1'b0, playerY_i}) - $signed({1'b0, curY_i});
    adx   = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    ady   = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    moveX = (adx >= ady);
    mag   = moveX ? adx : ady;
    if (mag > STEP_W) mag = STEP_W;
    sum        = '0;
    nextX_o    = curX_i;
    nextY_o    = curY_i;
    nextFace_o = curFace_i;
    if (mag != 11'd0) begin
      if (moveX) begin
        sum = dx[10] ? ($signed({3'b000, curX_i}) - $signed({2'b00, mag}))
                     : ($signed({3'b000, curX_i}) + $signed({2'b00, mag}));
        if (sum < 13'sd0)      nextX_o = 10'd0;
        else if (sum > X_HI)   nextX_o = X_HI[9:0];
        else                   nextX_o = sum[9:0];
        nextFace_o = dx[10] ? FACE_LEFT : FACE_RIGHT;
      end else begin
        sum = dy[10] ? ($signed({3'b000, curY_i}) - $signed({2'b00, mag}))
                     : ($signed({3'b000, curY_i}) + $signed({2'b00, mag}));
        if (sum < 13'sd0)      nextY_o = 10'd0;
        else if (sum > Y_HI)   nextY_o = Y_HI[9:0];
        else                   nextY_o = sum[9:0];
        nextFace_o = dy[10] ? FACE_UP : FACE_DOWN;
      end
    end
  end

endmodule

// File: rtl/zombie_controller.sv
// Three-zombie chase controller. Each frame tick starts a four-cycle
// sequence (UPD0, UPD1, UPD2, DONE) that moves one zombie per cycle through a
// shared stepper. Kill pulses park a zombie off-screen at any time.
// Optional feature macro: ZOMBIE_RESPAWN_EN brings dead zombies back after
// RESPAWN_FRAMES accepted ticks; without it they stay dead until Reset.
module zombie_controller
  import zombie_pkg::*;
#(
  parameter int STEP           = 1,
  parameter int RESPAWN_FRAMES = 120,
  parameter int MAX_X          = 608,
  parameter int MAX_Y          = 448
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [2:0] kill,
  output logic [9:0] Zombie0X,
  output logic [9:0] Zombie0Y,
  output logic [9:0] Zombie1X,
  output logic [9:0] Zombie1Y,
  output logic [9:0] Zombie2X,
  output logic [9:0] Zombie2Y,
  output logic [1:0] Zombie0Face,
  output logic [1:0] Zombie1Face,
  output logic [1:0] Zombie2Face,
  output logic [2:0] zombie_alive,
  output logic       busy
);

  state_e     state_q, state_d;
  logic       frameLvl_q, tick_q;
  logic [9:0] posX_q [NUM_ZOMBIES];
  logic [9:0] posX_d [NUM_ZOMBIES];
  logic [9:0] posY_q [NUM_ZOMBIES];
  logic [9:0] posY_d [NUM_ZOMBIES];
  face_e      face_q [NUM_ZOMBIES];
  face_e      face_d [NUM_ZOMBIES];
  logic [2:0] alive_q, alive_d;
  logic       updActive;
  logic [1:0] updIdx;
  logic [9:0] selX, selY, stepX, stepY;
  face_e      selFace, stepFace;

`ifdef ZOMBIE_RESPAWN_EN
  localparam logic [7:0] RESP_LIMIT = 8'(RESPAWN_FRAMES);
  logic [7:0] deadCnt_q [NUM_ZOMBIES];
  logic [7:0] deadCnt_d [NUM_ZOMBIES];
  logic       tickAccepted;
  assign tickAccepted = (state_q == IDLE) && tick_q;
`else
  // Without respawn the threshold has no hardware; this empty block only
  // keeps the parameter referenced so both builds share one interface.
  if (RESPAWN_FRAMES < 0) begin : gNoRespawn
  end
`endif

  // Remember the last vsync level and flag a 0->1 transition one cycle later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frameLvl_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      frameLvl_q <= frame_clk;
      tick_q     <= frame_clk & ~frameLvl_q;
    end
  end

  // Sequencer state register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Sequencer next state, busy flag, and which zombie the stepper serves.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    updActive = 1'b0;
    updIdx    = 2'd0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (tick_q) state_d = UPD0;
      end
      UPD0: begin
        updActive = 1'b1;
        updIdx    = 2'd0;
        state_d   = UPD1;
      end
      UPD1: begin
        updActive = 1'b1;
        updIdx    = 2'd1;
        state_d   = UPD2;
      end
      UPD2: begin
        updActive = 1'b1;
        updIdx    = 2'd2;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Route the zombie being updated this cycle into the shared stepper.
  always_comb begin
    selX    = posX_q[0];
    selY    = posY_q[0];
    selFace = face_q[0];
    if (updIdx == 2'd1) begin
      selX    = posX_q[1];
      selY    = posY_q[1];
      selFace = face_q[1];
    end else if (updIdx == 2'd2) begin
      selX    = posX_q[2];
      selY    = posY_q[2];
      selFace = face_q[2];
    end
  end

  zombie_step #(
    .STEP  (STEP),
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) uStep (
    .curX_i     (selX),
    .curY_i     (selY),
    .playerX_i  (PlayerX),
    .playerY_i  (PlayerY),
    .curFace_i  (selFace),
    .nextX_o    (stepX),
    .nextY_o    (stepY),
    .nextFace_o (stepFace)
  );

  // Per-zombie next state: a kill beats the move, dead zombies are skipped.
  always_comb begin
    alive_d = alive_q;
    for (int i = 0; i < NUM_ZOMBIES; i++) begin
      posX_d[i] = posX_q[i];
      posY_d[i] = posY_q[i];
      face_d[i] = face_q[i];
      if (kill[i] && alive_q[i]) begin
        alive_d[i] = 1'b0;
        posX_d[i]  = PARK_X;
        posY_d[i]  = PARK_Y;
      end else if (alive_q[i] && updActive && (updIdx == 2'(i))) begin
        posX_d[i] = stepX;
        posY_d[i] = stepY;
        face_d[i] = stepFace;
      end
`ifdef ZOMBIE_RESPAWN_EN
      else if (!alive_q[i] && (state_q == DONE) && (deadCnt_q[i] >= RESP_LIMIT)) begin
        alive_d[i] = 1'b1;
        posX_d[i]  = spawnX(i);
        posY_d[i]  = SPAWN_Y;
        face_d[i]  = FACE_DOWN;
      end
`endif
    end
  end

  // Zombie registers; Reset returns everyone to the spawn line facing down.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      alive_q <= 3'b111;
      for (int i = 0; i < NUM_ZOMBIES; i++) begin
        posX_q[i] <= spawnX(i);
        posY_q[i] <= SPAWN_Y;
        face_q[i] <= FACE_DOWN;
      end
    end else begin
      alive_q <= alive_d;
      for (int i = 0; i < NUM_ZOMBIES; i++) begin
        posX_q[i] <= posX_d[i];
        posY_q[i] <= posY_d[i];
        face_q[i] <= face_d[i];
      end
    end
  end

`ifdef ZOMBIE_RESPAWN_EN
  // Count accepted ticks while dead; cleared on death and on respawn.
  always_comb begin
    for (int i = 0; i < NUM_ZOMBIES; i++) begin
      deadCnt_d[i] = deadCnt_q[i];
      if (kill[i] && alive_q[i]) begin
        deadCnt_d[i] = 8'd0;
      end else if (!alive_q[i]) begin
        if ((state_q == DONE) && (deadCnt_q[i] >= RESP_LIMIT)) deadCnt_d[i] = 8'd0;
        else if (tickAccepted)                                 deadCnt_d[i] = deadCnt_q[i] + 8'd1;
      end
    end
  end

  // Respawn counter registers.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_ZOMBIES; i++) begin
      if (Reset) deadCnt_q[i] <= 8'd0;
      else       deadCnt_q[i] <= deadCnt_d[i];
    end
  end
`endif

  assign Zombie0X     = posX_q[0];
  assign Zombie0Y     = posY_q[0];
  assign Zombie1X     = posX_q[1];
  assign Zombie1Y     = posY_q[1];
  assign Zombie2X     = posX_q[2];
  assign Zombie2Y     = posY_q[2];
  assign Zombie0Face  = face_q[0];
  assign Zombie1Face  = face_q[1];
  assign Zombie2Face  = face_q[2];
  assign zombie_alive = alive_q;

endmodule

// File: tb/tb_zombie_controller.sv
// Self-checking bench for zombie_controller. A frame-level reference model
// (positions, faces, alive flags, dead-frame counts) is advanced once per
// accepted frame tick and compared against the DUT outputs.
// Honours ZOMBIE_RESPAWN_EN the same way the design does.
module tb_zombie_controller;

  localparam int STEP = 1;
  localparam int RF   = 3;
  localparam int MAXX = 608;
  localparam int MAXY = 448;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] PlayerX = '0;
  logic [9:0] PlayerY = '0;
  logic [2:0] kill = '0;
  logic [9:0] Zombie0X, Zombie0Y, Zombie1X, Zombie1Y, Zombie2X, Zombie2Y;
  logic [1:0] Zombie0Face, Zombie1Face, Zombie2Face;
  logic [2:0] zombie_alive;
  logic       busy;

  int numCompared = 0;
  int numMismatched = 0;

  int mX [3];
  int mY [3];
  int mFace [3];
  int mAlive [3];
  int mCnt [3];
  int pX = 0;
  int pY = 0;

  zombie_controller #(
    .STEP           (STEP),
    .RESPAWN_FRAMES (RF),
    .MAX_X          (MAXX),
    .MAX_Y          (MAXY)
  ) dut (
    .Clk          (clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .PlayerX      (PlayerX),
    .PlayerY      (PlayerY),
    .kill         (kill),
    .Zombie0X     (Zombie0X),
    .Zombie0Y     (Zombie0Y),
    .Zombie1X     (Zombie1X),
    .Zombie1Y     (Zombie1Y),
    .Zombie2X     (Zombie2X),
    .Zombie2Y     (Zombie2Y),
    .Zombie0Face  (Zombie0Face),
    .Zombie1Face  (Zombie1Face),
    .Zombie2Face  (Zombie2Face),
    .zombie_alive (zombie_alive),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void modelReset();
    for (int n = 0; n < 3; n++) begin
      mX[n]     = (n == 0) ? 32 : (n == 1) ? 304 : 576;
      mY[n]     = 32;
      mFace[n]  = 2;
      mAlive[n] = 1;
      mCnt[n]   = 0;
    end
  endfunction

  function automatic void modelKill(input int n);
    if (mAlive[n] == 1) begin
      mAlive[n] = 0;
      mX[n]     = 640;
      mY[n]     = 480;
      mCnt[n]   = 0;
    end
  endfunction

  // One frame for one zombie: chase if alive, otherwise count toward respawn.
  function automatic void modelZombieTick(input int n);
    int dx, dy, adx, ady, mag, v;
    if (mAlive[n] == 1) begin
      dx  = pX - mX[n];
      dy  = pY - mY[n];
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      if (adx == 0 && ady == 0) return;
      if (adx >= ady) begin
        mag = (adx < STEP) ? adx : STEP;
        v = mX[n] + ((dx > 0) ? mag : -mag);
        if (v < 0) v = 0;
        if (v > MAXX - 1) v = MAXX - 1;
        mX[n] = v;
        mFace[n] = (dx > 0) ? 1 : 3;
      end else begin
        mag = (ady < STEP) ? ady : STEP;
        v = mY[n] + ((dy > 0) ? mag : -mag);
        if (v < 0) v = 0;
        if (v > MAXY - 1) v = MAXY - 1;
        mY[n] = v;
        mFace[n] = (dy > 0) ? 2 : 0;
      end
    end else begin
      mCnt[n]++;
`ifdef ZOMBIE_RESPAWN_EN
      if (mCnt[n] >= RF) begin
        mAlive[n] = 1;
        mX[n]     = (n == 0) ? 32 : (n == 1) ? 304 : 576;
        mY[n]     = 32;
        mFace[n]  = 2;
        mCnt[n]   = 0;
      end
`endif
    end
  endfunction

  function automatic void modelTick();
    for (int n = 0; n < 3; n++) modelZombieTick(n);
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".z0x"}, Zombie0X, mX[0]);
    checkOutput({tag, ".z0y"}, Zombie0Y, mY[0]);
    checkOutput({tag, ".z0f"}, Zombie0Face, mFace[0]);
    checkOutput({tag, ".z1x"}, Zombie1X, mX[1]);
    checkOutput({tag, ".z1y"}, Zombie1Y, mY[1]);
    checkOutput({tag, ".z1f"}, Zombie1Face, mFace[1]);
    checkOutput({tag, ".z2x"}, Zombie2X, mX[2]);
    checkOutput({tag, ".z2y"}, Zombie2Y, mY[2]);
    checkOutput({tag, ".z2f"}, Zombie2Face, mFace[2]);
    checkOutput({tag, ".alive"}, zombie_alive, mAlive[0] + 2 * mAlive[1] + 4 * mAlive[2]);
  endtask

  // Set the player position and optionally pulse kill for one cycle.
  task automatic applyStimulus(input int px, input int py, input logic [2:0] killMask);
    pX = px;
    pY = py;
    PlayerX = 10'(px);
    PlayerY = 10'(py);
    if (killMask != 3'b000) begin
      kill = killMask;
      cycle(1);
      kill = 3'b000;
      for (int n = 0; n < 3; n++) if (killMask[n]) modelKill(n);
    end
    cycle(1);
  endtask

  task automatic waitBusy(input string tag, input logic level, input int budget);
    int waited = 0;
    while (busy !== level && waited < budget) begin
      cycle(1);
      waited++;
    end
    checkOutput(tag, busy, level);
  endtask

  // Raise vsync once, let the update sequence run to completion.
  task automatic pulseFrame(input string tag);
    frame_clk = 1'b1;
    waitBusy({tag, ".busyRise"}, 1'b1, 6);
    waitBusy({tag, ".busyFall"}, 1'b0, 10);
    frame_clk = 1'b0;
    cycle(1);
    modelTick();
  endtask

  task automatic doReset();
    Reset = 1'b1;
    frame_clk = 1'b0;
    kill = 3'b000;
    cycle(2);
    Reset = 1'b0;
    modelReset();
    cycle(1);
  endtask

  initial begin
    $display("[TB] zombie_controller bench start");
    doReset();
    checkAll("reset");
    checkOutput("reset.busy", busy, 0);

    // First tick toward (100,40): exact sequence timing and zombie0 result.
    applyStimulus(100, 40, 3'b000);
    frame_clk = 1'b1;
    cycle(1);
    checkOutput("timing.busyC1", busy, 0);
    cycle(1);
    checkOutput("timing.busyC2", busy, 1);
    cycle(3);
    checkOutput("timing.busyC5", busy, 1);
    checkOutput("first.z0x", Zombie0X, 33);
    checkOutput("first.z0y", Zombie0Y, 32);
    checkOutput("first.z0f", Zombie0Face, 1);
    cycle(1);
    checkOutput("timing.busyC6", busy, 0);
    frame_clk = 1'b0;
    cycle(1);
    modelTick();
    checkAll("first");

    // Player exactly on zombie0: zombie0 holds position and face.
    doReset();
    applyStimulus(32, 32, 3'b000);
    pulseFrame("onTop");
    checkAll("onTop");
    checkOutput("onTop.z0f", Zombie0Face, 2);

    // A second vsync edge two cycles after the first is dropped.
    doReset();
    applyStimulus(500, 300, 3'b000);
    frame_clk = 1'b1;
    cycle(1);
    frame_clk = 1'b0;
    cycle(1);
    frame_clk = 1'b1;
    cycle(1);
    frame_clk = 1'b0;
    cycle(10);
    modelTick();
    checkAll("dropTick");
    checkOutput("dropTick.busy", busy, 0);

    // Kill zombie1 during its own update cycle: park, no move.
    doReset();
    applyStimulus(200, 300, 3'b000);
    frame_clk = 1'b1;
    waitBusy("killUpd.busyRise", 1'b1, 6);
    cycle(1);
    kill = 3'b010;
    cycle(1);
    kill = 3'b000;
    waitBusy("killUpd.busyFall", 1'b0, 10);
    frame_clk = 1'b0;
    cycle(1);
    modelZombieTick(0);
    modelKill(1);
    modelZombieTick(2);
    checkAll("killUpd");
    checkOutput("killUpd.z1x", Zombie1X, 640);
    checkOutput("killUpd.z1y", Zombie1Y, 480);
    checkOutput("killUpd.alive", zombie_alive, 5);

    // Respawn behaviour; a repeat kill on a dead zombie is ignored.
    doReset();
    applyStimulus(100, 100, 3'b010);
    pulseFrame("resp1");
    applyStimulus(100, 100, 3'b010);
    pulseFrame("resp2");
    pulseFrame("resp3");
    checkAll("resp3");
`ifdef ZOMBIE_RESPAWN_EN
    checkOutput("resp.z1x", Zombie1X, 304);
    checkOutput("resp.z1y", Zombie1Y, 32);
    checkOutput("resp.alive", zombie_alive, 7);
`else
    for (int t = 3; t < 200; t++) pulseFrame("stayDead");
    checkAll("stayDead");
    checkOutput("stayDead.z1x", Zombie1X, 640);
    checkOutput("stayDead.alive", zombie_alive, 5);
`endif

    // Clamp at the right and bottom edges of the playfield.
    doReset();
    applyStimulus(639, 479, 3'b000);
    for (int t = 0; t < 40; t++) pulseFrame("edgeA");
    checkAll("edgeA");
    applyStimulus(1023, 32, 3'b000);
    for (int t = 0; t < 40; t++) pulseFrame("edgeB");
    checkAll("edgeB");
    checkOutput("edgeB.z2x", Zombie2X, 607);
    applyStimulus(1023, 1023, 3'b000);
    for (int t = 0; t < 30; t++) pulseFrame("edgeC");
    checkAll("edgeC");

    // Randomized chase with occasional kills and mid-sequence resets.
    doReset();
    for (int it = 0; it < 80; it++) begin
      logic [2:0] km;
      km = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
      applyStimulus(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)), km);
      checkAll("rndKill");
      if (it % 20 == 19) begin
        frame_clk = 1'b1;
        waitBusy("midReset.busyRise", 1'b1, 6);
        cycle(1);
        Reset = 1'b1;
        frame_clk = 1'b0;
        cycle(1);
        Reset = 1'b0;
        modelReset();
        cycle(1);
        checkAll("midReset");
        checkOutput("midReset.busy", busy, 0);
      end else begin
        pulseFrame("rnd");
        checkAll("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
